// File: rtl/pipe_sequencer_if.sv
// rtl/pipe_sequencer_if.sv - control/status bundle between pipe_sequencer and its pipeline controller
interface pipe_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             mem_busy;
    logic [3:0]       pipe_state;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    modport master (
        output start, halt_req, mem_busy,
        input  pipe_state, running, halted, cycle_count, stall_count, timeout_err
    );

    modport slave (
        input  start, halt_req, mem_busy,
        output pipe_state, running, halted, cycle_count, stall_count, timeout_err
    );
endinterface

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - per-stage enable sequencer: fill, run, mem-wait freeze, halt drain
// Optional memory-wait timeout built when PIPE_SEQ_TIMEOUT_EN is defined.
module pipe_sequencer #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic            CLK,
    input  logic            RST,
    pipe_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       v_q, v_d;
    logic             pend_q, pend_d;
    logic             frozen;
    logic             running_w;
    logic [CNT_W-1:0] cyc_q, stall_q;

    assign frozen    = bus.mem_busy && (v_q != 4'b0000);
    assign running_w = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);

`ifdef PIPE_SEQ_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        pend_d  = pend_q;
        if (frozen) begin
            // a halt seen during a freeze is remembered until the stages move again
            if ((state_q == S_FILL || state_q == S_RUN) && bus.halt_req) begin
                pend_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        v_d     = 4'b0001;
                        state_d = S_FILL;
                        pend_d  = 1'b0;
                    end
                end
                S_FILL, S_RUN: begin
                    if (bus.halt_req || pend_q) begin
                        v_d     = {v_q[2:0], 1'b0};
                        state_d = S_DRAIN;
                        pend_d  = 1'b0;
                    end else if (state_q == S_FILL) begin
                        v_d = {v_q[2:0], 1'b1};
                        if ({v_q[2:0], 1'b1} == 4'b1111) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_DRAIN: begin
                    v_d = {v_q[2:0], 1'b0};
                    if (v_q[2:0] == 3'b000) begin
                        state_d = S_HALTED;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    v_d     = 4'b0000;
                    pend_d  = 1'b0;
                end
            endcase
        end
`ifdef PIPE_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
        wait_d    = frozen ? wait_q + 1'b1 : '0;
        // the wait about to reach MAX_WAIT abandons the program and parks in HALTED
        if (frozen && (wait_q == WAIT_W'(MAX_WAIT - 1))) begin
            timeout_d = 1'b1;
            v_d       = 4'b0000;
            state_d   = S_HALTED;
            pend_d    = 1'b0;
            wait_d    = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            v_q     <= 4'b0000;
            pend_q  <= 1'b0;
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            if (running_w && (cyc_q != {CNT_W{1'b1}})) begin
                cyc_q <= cyc_q + 1'b1;
            end
            if (frozen && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

`ifdef PIPE_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.pipe_state  = frozen ? 4'b0000 : v_q;
    assign bus.running     = running_w;
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.cycle_count = cyc_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - directed self-checking bench for pipe_sequencer
module tb_pipe_sequencer;
    logic CLK = 1'b0;
    logic RST;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cyc = 0;
    int   exp_stall = 0;

    pipe_sequencer_if #(.CNT_W(32)) bus ();

    pipe_sequencer #(.CNT_W(32), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bus.start = 1'b1;
        bus.halt_req = 1'b0;
        bus.mem_busy = 1'b0;
        step();
        step();
        checks++; if (bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL reset_pipe got %b want 0000", bus.pipe_state); end
        checks++; if (bus.running !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%b halt=%b want 0 0", bus.running, bus.halted); end
        checks++; if (bus.cycle_count !== 32'd0 || bus.stall_count !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d %0d want 0 0", bus.cycle_count, bus.stall_count); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.timeout_err); end
        RST = 1'b0;
        bus.start = 1'b0;
        step();
        checks++; if (bus.pipe_state !== 4'b0000 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_hold got %b run=%b want 0000 run=0", bus.pipe_state, bus.running); end
        exp_cyc = 0;
        exp_stall = 0;
    endtask

    task automatic test_fill;
        logic [3:0] exp_v [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        int base;
        base = exp_cyc;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            checks++; if (bus.pipe_state !== exp_v[i]) begin errors++; $display("FAIL fill_pipe[%0d] got %b want %b", i, bus.pipe_state, exp_v[i]); end
            checks++; if (bus.running !== 1'b1 || bus.halted !== 1'b0) begin errors++; $display("FAIL fill_flags[%0d] got run=%b halt=%b want 1 0", i, bus.running, bus.halted); end
            checks++; if (bus.cycle_count !== 32'(base + i)) begin errors++; $display("FAIL fill_cycles[%0d] got %0d want %0d", i, bus.cycle_count, base + i); end
        end
        exp_cyc = base + 4;
    endtask

    task automatic test_halt;
        logic [3:0] exp_v [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        int base;
        base = exp_cyc;
        bus.halt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.halt_req = 1'b0;
            checks++; if (bus.pipe_state !== exp_v[i]) begin errors++; $display("FAIL drain_pipe[%0d] got %b want %b", i, bus.pipe_state, exp_v[i]); end
            checks++; if (bus.running !== (i < 3) || bus.halted !== (i == 3)) begin errors++; $display("FAIL drain_flags[%0d] got run=%b halt=%b", i, bus.running, bus.halted); end
            checks++; if (bus.cycle_count !== 32'(base + 1 + i)) begin errors++; $display("FAIL drain_cycles[%0d] got %0d want %0d", i, bus.cycle_count, base + 1 + i); end
        end
        exp_cyc = base + 4;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        checks++; if (bus.halted !== 1'b1 || bus.pipe_state !== 4'b0000 || bus.cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL halted_hold got halt=%b pipe=%b cyc=%0d want 1 0000 %0d", bus.halted, bus.pipe_state, bus.cycle_count, exp_cyc); end
    endtask

    task automatic test_stall;
        int base_c;
        int base_s;
        base_c = exp_cyc;
        base_s = exp_stall;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL stall_pipe[%0d] got %b want 0000", i, bus.pipe_state); end
            step();
        end
        bus.mem_busy = 1'b0;
        #1;
        checks++; if (bus.pipe_state !== 4'b1111) begin errors++; $display("FAIL stall_resume got %b want 1111", bus.pipe_state); end
        checks++; if (bus.stall_count !== 32'(base_s + 5)) begin errors++; $display("FAIL stall_count got %0d want %0d", bus.stall_count, base_s + 5); end
        checks++; if (bus.cycle_count !== 32'(base_c + 5)) begin errors++; $display("FAIL stall_cycles got %0d want %0d", bus.cycle_count, base_c + 5); end
        exp_cyc = base_c + 5;
        exp_stall = base_s + 5;
    endtask

    task automatic test_halt_busy;
        logic [3:0] exp_v [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        int base_c;
        int base_s;
        base_c = exp_cyc;
        base_s = exp_stall;
        bus.halt_req = 1'b1;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL hb_frozen[%0d] got %b want 0000", i, bus.pipe_state); end
            step();
        end
        bus.halt_req = 1'b0;
        bus.mem_busy = 1'b0;
        #1;
        checks++; if (bus.pipe_state !== 4'b1111) begin errors++; $display("FAIL hb_release got %b want 1111", bus.pipe_state); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.pipe_state !== exp_v[i]) begin errors++; $display("FAIL hb_drain[%0d] got %b want %b", i, bus.pipe_state, exp_v[i]); end
        end
        checks++; if (bus.halted !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL hb_halted got halt=%b run=%b want 1 0", bus.halted, bus.running); end
        checks++; if (bus.stall_count !== 32'(base_s + 3)) begin errors++; $display("FAIL hb_stall got %0d want %0d", bus.stall_count, base_s + 3); end
        checks++; if (bus.cycle_count !== 32'(base_c + 7)) begin errors++; $display("FAIL hb_cycles got %0d want %0d", bus.cycle_count, base_c + 7); end
        exp_cyc = base_c + 7;
        exp_stall = base_s + 3;
    endtask

    task automatic test_reset_mid_fill;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++; if (bus.pipe_state !== 4'b0011) begin errors++; $display("FAIL midfill_pre got %b want 0011", bus.pipe_state); end
        RST = 1'b1;
        bus.start = 1'b1;
        step();
        checks++; if (bus.pipe_state !== 4'b0000 || bus.running !== 1'b0) begin errors++; $display("FAIL midfill_abort got %b run=%b want 0000 0", bus.pipe_state, bus.running); end
        checks++; if (bus.cycle_count !== 32'd0 || bus.stall_count !== 32'd0) begin errors++; $display("FAIL midfill_counts got %0d %0d want 0 0", bus.cycle_count, bus.stall_count); end
        step();
        checks++; if (bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL midfill_start_in_rst got %b want 0000", bus.pipe_state); end
        RST = 1'b0;
        bus.start = 1'b0;
        step();
        checks++; if (bus.pipe_state !== 4'b0000 || bus.halted !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("FAIL midfill_idle got %b halt=%b run=%b", bus.pipe_state, bus.halted, bus.running); end
        exp_cyc = 0;
        exp_stall = 0;
    endtask

    task automatic test_timeout;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL to_pipe[%0d] got %b want 0000", i, bus.pipe_state); end
            step();
`ifdef PIPE_SEQ_TIMEOUT_EN
            checks++; if (bus.timeout_err !== (i == 3)) begin errors++; $display("FAIL to_flag[%0d] got %b want %b", i, bus.timeout_err, i == 3); end
`else
            checks++; if (bus.timeout_err !== 1'b0 || bus.running !== 1'b1) begin errors++; $display("FAIL to_flag[%0d] got to=%b run=%b want 0 1", i, bus.timeout_err, bus.running); end
`endif
        end
`ifdef PIPE_SEQ_TIMEOUT_EN
        checks++; if (bus.halted !== 1'b1 || bus.pipe_state !== 4'b0000) begin errors++; $display("FAIL to_halted got halt=%b pipe=%b want 1 0000", bus.halted, bus.pipe_state); end
        bus.mem_busy = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.pipe_state !== 4'b0001 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_restart got pipe=%b to=%b want 0001 1", bus.pipe_state, bus.timeout_err); end
`else
        step();
        checks++; if (bus.pipe_state !== 4'b0000 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_hold got pipe=%b to=%b want 0000 0", bus.pipe_state, bus.timeout_err); end
        bus.mem_busy = 1'b0;
        #1;
        checks++; if (bus.pipe_state !== 4'b1111) begin errors++; $display("FAIL to_resume got %b want 1111", bus.pipe_state); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_halt();
        test_fill();
        test_stall();
        test_halt_busy();
        test_reset_mid_fill();
        test_fill();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
